// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NumReq byte-stream requesters.
// Handshake: byte k moves on the cycle where i_req_valid[k] & o_req_ready[k]; ready is only offered to the owner.
module uart_tx_arbiter #(
   parameter int NumReq      = 4,
   parameter int DataLength  = 8,
   parameter int MaxBurst    = 16,
   parameter int IdleTimeout = 1024
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [NumReq-1:0]              i_req_valid,
   input  logic [NumReq*DataLength-1:0]   i_req_data,
   input  logic [NumReq-1:0]              i_req_last,
   output logic [NumReq-1:0]              o_req_ready,
   output logic [NumReq-1:0]              o_grant,
   output logic [$clog2(NumReq)-1:0]      o_grant_id,
   output logic [DataLength-1:0]          o_tx_data,
   output logic                           o_tx_start,
   input  logic                           i_tx_busy,
   output logic [2:0]                     o_dbg_state
);

   localparam int IdW    = $clog2(NumReq);
   localparam int BurstW = $clog2(MaxBurst + 1);
   localparam int IdleW  = $clog2(IdleTimeout + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HOLD  = 3'd1,
      START = 3'd2,
      ACK   = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [IdW-1:0]         ptr_q;
   logic [IdW-1:0]         pick_id;
   logic                   pick_found;
   logic                   last_q;
   logic [BurstW-1:0]      burst_q;
   logic [IdleW-1:0]       idle_cnt_q;
   logic [DataLength-1:0]  req_bytes [NumReq];
   logic                   owner_valid;
   logic                   xfer;
   logic                   timeout;
   logic                   burst_done;

   for (genvar k = 0; k < NumReq; k++) begin : g_unpack
      assign req_bytes[k] = i_req_data[k*DataLength +: DataLength];
   end

   // First valid requester scanning upward from the one after the last owner.
   always_comb begin
      int unsigned idx;
      logic [IdW-1:0] cand;
      idx        = 0;
      cand       = '0;
      pick_found = 1'b0;
      pick_id    = ptr_q;
      for (int i = 1; i <= NumReq; i++) begin
         idx  = (int'(ptr_q) + i) % NumReq;
         cand = IdW'(idx);
         if (!pick_found && i_req_valid[cand]) begin
            pick_found = 1'b1;
            pick_id    = cand;
         end
      end
   end

   assign owner_valid = i_req_valid[o_grant_id];
   assign xfer        = (state_q == HOLD) && owner_valid && !i_tx_busy;
   assign timeout     = (state_q == HOLD) && !owner_valid &&
                        (idle_cnt_q == IdleW'(IdleTimeout - 1));
   assign burst_done  = last_q || (burst_q == BurstW'(MaxBurst));
   assign o_req_ready = ((state_q == HOLD) && !i_tx_busy) ? (o_grant & i_req_valid) : '0;
   assign o_dbg_state = state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_found) state_d = HOLD;
         HOLD: begin
            if (xfer)         state_d = START;
            else if (timeout) state_d = IDLE;
         end
         START:   state_d = ACK;
         ACK:     if (i_tx_busy) state_d = DRAIN;
         DRAIN:   if (!i_tx_busy) state_d = burst_done ? IDLE : HOLD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_grant    <= '0;
         o_grant_id <= IdW'(NumReq - 1);
         ptr_q      <= IdW'(NumReq - 1);
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
         last_q     <= 1'b0;
         burst_q    <= '0;
         idle_cnt_q <= '0;
      end else begin
         o_tx_start <= (state_d == START);
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  o_grant          <= '0;
                  o_grant[pick_id] <= 1'b1;
                  o_grant_id       <= pick_id;
                  burst_q          <= '0;
                  idle_cnt_q       <= '0;
               end
            end
            HOLD: begin
               if (xfer) begin
                  o_tx_data <= req_bytes[o_grant_id];
                  last_q    <= i_req_last[o_grant_id];
                  burst_q   <= burst_q + 1'b1;
               end else if (timeout) begin
                  ptr_q   <= o_grant_id;
                  o_grant <= '0;
               end else if (!owner_valid) begin
                  idle_cnt_q <= idle_cnt_q + 1'b1;
               end
            end
            DRAIN: begin
               if (!i_tx_busy) begin
                  if (burst_done) begin
                     ptr_q   <= o_grant_id;
                     o_grant <= '0;
                  end else begin
                     idle_cnt_q <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
